// File: rtl/kp_pkg.sv
// kp_pkg: shared MIDI constants, FSM encodings and note helpers
// for the Karplus-Strong MIDI voice controller.
package kp_pkg;

  localparam int FS_HZ    = 96000;
  localparam int MIN_NOTE = 43;

  localparam logic [3:0] NOTE_OFF    = 4'h8;
  localparam logic [3:0] NOTE_ON     = 4'h9;
  localparam logic [3:0] CC          = 4'hB;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;

  typedef enum logic [2:0] {
    P_IDLE,
    P_DATA1,
    P_DATA2,
    P_SKIP1,
    P_SYSEX
  } parse_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_HOLD,
    T_GAP
  } trig_t;

  function automatic logic [6:0] fold_note(
    input logic [6:0] n,
    input int         min_n
  );
    logic [6:0] f;
    f = n;
    for (int i = 0; i < 11; i++)
      if (int'(f) < min_n) f = f + 7'd12;
    return f;
  endfunction

  // Elaboration-time only: period in samples, saturated to 10 bits
  function automatic logic [9:0] note_period(
    input int n,
    input int fs
  );
    real p;
    p = real'(fs) / (440.0 * (2.0 ** (real'(n - 69) / 12.0)));
    if (p > 1023.0) return 10'd1023;
    return 10'($rtoi(p + 0.5));
  endfunction

endpackage

// File: rtl/kp_note_period_rom.sv
// kp_note_period_rom: 128x10 note-to-period table with a
// registered output, built at elaboration from the sample rate.
module kp_note_period_rom
  import kp_pkg::*;
#(
  parameter int FS = FS_HZ
) (
  input  logic       i_clk,
  input  logic [6:0] i_addr,
  output logic [9:0] o_q
);

  logic [9:0] w_tab [128];
  logic [9:0] r_q;

  for (genvar g = 0; g < 128; g++) begin : g_rom
    localparam logic [9:0] P = note_period(g, FS);
    assign w_tab[g] = P;
  end

  always_ff @(posedge i_clk)
    r_q <= w_tab[i_addr];

  assign o_q = r_q;

endmodule

// File: rtl/kp_midi_voice_ctrl.sv
// kp_midi_voice_ctrl: monophonic last-note MIDI front end for the KP voice.
// Define KP_MIDI_CC_EN to enable CC74 filter select and CC72 release decay.
module kp_midi_voice_ctrl
  import kp_pkg::*;
#(
  parameter int          TRIG_HOLD     = 8,
  parameter int          TRIG_GAP      = 8,
  parameter logic [11:0] SUSTAIN_DECAY = 12'd4090,
  parameter logic [11:0] RELEASE_DECAY = 12'd3800,
  parameter logic [2:0]  FILT_DEFAULT  = 3'd2
) (
  input  logic        audio_clk,
  input  logic        reset,
  input  logic [3:0]  midi_chan,
  input  logic [7:0]  midi_byte,
  input  logic        midi_valid,
  output logic        trig,
  output logic [6:0]  velocity,
  output logic [9:0]  delay_length,
  output logic [11:0] decay,
  output logic [2:0]  filtsw,
  output logic        note_active,
  output logic [6:0]  cur_note
);

  parse_t      r_pst;
  logic [7:0]  r_rs;
  logic        r_rs_vld;
  logic [6:0]  r_d1;
  logic        r_on;
  logic        r_off;
  logic [6:0]  r_evn;
  logic [6:0]  r_evv;

  trig_t       r_tst;
  logic [7:0]  r_tcnt;
  logic        r_trig;
  logic [6:0]  r_vel;
  logic [9:0]  r_len;
  logic [11:0] r_dec;
  logic        r_act;
  logic [6:0]  r_cur;

  logic [6:0]  w_addr;
  logic [9:0]  w_period;
  logic [11:0] w_rel;
  logic [2:0]  w_filt;
  logic [3:0]  w_type;
  logic        w_match;
  logic        w_rt, w_sx, w_sxs, w_sys;
  logic        w_chs, w_dat;
  logic        w_non, w_noff;

  // Byte classes are mutually exclusive and cover every byte
  assign w_rt  = midi_byte[7:3] == 5'b11111;
  assign w_sx  = !w_rt && r_pst == P_SYSEX;
  assign w_sxs = !w_rt && r_pst != P_SYSEX &&
                 midi_byte == SYSEX_START;
  assign w_sys = !w_rt && r_pst != P_SYSEX &&
                 midi_byte[7:4] == 4'hF &&
                 midi_byte != SYSEX_START;
  assign w_chs = r_pst != P_SYSEX && midi_byte[7] &&
                 midi_byte[7:4] != 4'hF;
  assign w_dat = r_pst != P_SYSEX && !midi_byte[7];

  assign w_type  = r_rs[7:4];
  assign w_match = r_rs[3:0] == midi_chan;
  assign w_non   = w_type == NOTE_ON && midi_byte[6:0] != 7'd0;
  assign w_noff  = w_type == NOTE_OFF ||
                   (w_type == NOTE_ON && midi_byte[6:0] == 7'd0);

`ifdef KP_MIDI_CC_EN
  logic [2:0]  r_filt;
  logic [11:0] r_rel;
  logic        w_cc74, w_cc72;
  assign w_cc74 = w_type == CC && r_d1 == 7'd74;
  assign w_cc72 = w_type == CC && r_d1 == 7'd72;
  assign w_filt = r_filt;
  assign w_rel  = r_rel;
`else
  assign w_filt = FILT_DEFAULT;
  assign w_rel  = RELEASE_DECAY;
`endif

  always_ff @(posedge audio_clk) begin
    if (reset) begin
      r_pst    <= P_IDLE;
      r_rs     <= 8'h00;
      r_rs_vld <= 1'b0;
      r_d1     <= 7'd0;
      r_on     <= 1'b0;
      r_off    <= 1'b0;
      r_evn    <= 7'd0;
      r_evv    <= 7'd0;
`ifdef KP_MIDI_CC_EN
      r_filt   <= FILT_DEFAULT;
      r_rel    <= RELEASE_DECAY;
`endif
    end else begin
      r_on  <= 1'b0;
      r_off <= 1'b0;
      if (midi_valid) begin
        unique case (1'b1)
          w_rt: ;
          w_sx: if (midi_byte == SYSEX_END) r_pst <= P_IDLE;
          w_sxs: begin
            r_pst    <= P_SYSEX;
            r_rs_vld <= 1'b0;
          end
          w_sys: begin
            r_pst    <= P_IDLE;
            r_rs_vld <= 1'b0;
          end
          w_chs: begin
            r_rs     <= midi_byte;
            r_rs_vld <= 1'b1;
            r_pst    <= (midi_byte[7:5] == 3'b110) ?
                        P_SKIP1 : P_DATA1;
          end
          w_dat: begin
            unique case (r_pst)
              P_IDLE: begin
                if (r_rs_vld && r_rs[7:5] != 3'b110) begin
                  r_d1  <= midi_byte[6:0];
                  r_pst <= P_DATA2;
                end
              end
              P_DATA1: begin
                r_d1  <= midi_byte[6:0];
                r_pst <= P_DATA2;
              end
              P_DATA2: begin
                r_pst <= P_IDLE;
                if (w_match) begin
                  unique case (1'b1)
                    w_non: begin
                      r_on  <= 1'b1;
                      r_evn <= r_d1;
                      r_evv <= midi_byte[6:0];
                    end
                    w_noff: begin
                      r_off <= 1'b1;
                      r_evn <= r_d1;
                    end
`ifdef KP_MIDI_CC_EN
                    w_cc74: r_filt <= midi_byte[6:4];
                    w_cc72: r_rel  <= 12'd3072 +
                      {2'b00, midi_byte[6:0], 3'b000};
`endif
                    default: ;
                  endcase
                end
              end
              P_SKIP1: r_pst <= P_IDLE;
              default: r_pst <= P_IDLE;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // ROM address is the held DATA1 note, so the period is ready one cycle after dispatch
  assign w_addr = fold_note(r_d1, MIN_NOTE);

  kp_note_period_rom #(
    .FS (FS_HZ)
  ) u_rom (
    .i_clk  (audio_clk),
    .i_addr (w_addr),
    .o_q    (w_period)
  );

  always_ff @(posedge audio_clk) begin
    if (reset) begin
      r_trig <= 1'b1;
      r_vel  <= 7'd0;
      r_len  <= 10'd218;
      r_dec  <= RELEASE_DECAY;
      r_act  <= 1'b0;
      r_cur  <= 7'd69;
      r_tst  <= T_IDLE;
      r_tcnt <= 8'd0;
    end else begin
      if (r_on) begin
        r_cur <= r_evn;
        r_vel <= r_evv;
        r_act <= 1'b1;
        r_dec <= SUSTAIN_DECAY;
        r_len <= w_period;
      end else if (r_off && r_evn == r_cur) begin
        r_act <= 1'b0;
        r_dec <= w_rel;
      end
      unique case (r_tst)
        T_IDLE: begin
          if (r_on) begin
            r_tst  <= T_HOLD;
            r_trig <= 1'b0;
            r_tcnt <= 8'(TRIG_HOLD - 1);
          end
        end
        T_HOLD: begin
          if (r_on) begin
            r_tst  <= T_GAP;
            r_trig <= 1'b1;
            r_tcnt <= 8'(TRIG_GAP - 1);
          end else if (r_tcnt == 8'd0) begin
            r_tst  <= T_IDLE;
            r_trig <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt - 8'd1;
          end
        end
        T_GAP: begin
          if (r_tcnt == 8'd0) begin
            r_tst  <= T_HOLD;
            r_trig <= 1'b0;
            r_tcnt <= 8'(TRIG_HOLD - 1);
          end else begin
            r_tcnt <= r_tcnt - 8'd1;
          end
        end
        default: begin
          r_tst  <= T_IDLE;
          r_trig <= 1'b1;
        end
      endcase
    end
  end

  assign trig         = r_trig;
  assign velocity     = r_vel;
  assign delay_length = r_len;
  assign decay        = r_dec;
  assign filtsw       = w_filt;
  assign note_active  = r_act;
  assign cur_note     = r_cur;

endmodule
